// File: rtl/fetch_ifu_ctrl_if.sv
// Bundle of the fetch controller's redirect, IF request/response and decode-side signals.
// The master modport is the controller's view; slave is the bus/decode/execute view.
interface fetch_ifu_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   redirect_valid_i;
    logic [PC_WIDTH-1:0]    redirect_pc_i;
    logic                   if_req_valid_o;
    logic                   if_req_ready_i;
    logic [PC_WIDTH-1:0]    if_req_pc_o;
    logic                   if_resp_valid_i;
    logic                   if_resp_ready_o;
    logic                   if_resp_err_i;
    logic [INSTR_WIDTH-1:0] if_resp_instr_i;
    logic                   ifu_o_valid_o;
    logic                   ifu_o_ready_i;
    logic [PC_WIDTH-1:0]    ifu_o_pc_o;
    logic [INSTR_WIDTH-1:0] ifu_o_instr_o;
    logic                   ifu_o_err_o;

    modport master (
        input  redirect_valid_i, redirect_pc_i,
        output if_req_valid_o, if_req_pc_o,
        input  if_req_ready_i,
        input  if_resp_valid_i, if_resp_err_i, if_resp_instr_i,
        output if_resp_ready_o,
        output ifu_o_valid_o, ifu_o_pc_o, ifu_o_instr_o, ifu_o_err_o,
        input  ifu_o_ready_i
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i,
        input  if_req_valid_o, if_req_pc_o,
        output if_req_ready_i,
        output if_resp_valid_i, if_resp_err_i, if_resp_instr_i,
        input  if_resp_ready_o,
        input  ifu_o_valid_o, ifu_o_pc_o, ifu_o_instr_o, ifu_o_err_o,
        output ifu_o_ready_i
    );
endinterface

// File: rtl/fetch_ifu_ctrl.sv
// Fetch controller: owns the PC, keeps one IF request in flight, buffers one instruction
// for decode, and handles redirects, stale responses and halting on bus errors.
module fetch_ifu_ctrl #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(32'h8000_0000)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fetch_ifu_ctrl_if.master  bus
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]             state_q,     state_d;
    logic [PC_WIDTH-1:0]    pc_q,        pc_d;
    logic [PC_WIDTH-1:0]    ret_pc_q,    ret_pc_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [PC_WIDTH-1:0]    buf_pc_q,    buf_pc_d;
    logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic                   buf_err_q,   buf_err_d;

    logic buf_free;
    logic req_valid;
    logic resp_ready;
    logic req_hs;
    logic resp_hs;

    // A request is only offered when the buffer is guaranteed to have room for its response.
    always_comb begin
        buf_free   = !buf_valid_q | bus.ifu_o_ready_i;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_REQ:  req_valid  = buf_free & !bus.redirect_valid_i;
                ST_WAIT: resp_ready = buf_free;
                ST_DROP: resp_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign req_hs  = req_valid & bus.if_req_ready_i;
    assign resp_hs = resp_ready & bus.if_resp_valid_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ret_pc_d    = ret_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_err_d   = buf_err_q;

        if (bus.ifu_o_ready_i) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (req_hs) begin
                    state_d  = ST_WAIT;
                    ret_pc_d = pc_q;
                    pc_d     = pc_q + PC_WIDTH'(4);
                end
            end
            ST_WAIT: begin
                if (resp_hs) begin
                    buf_valid_d = 1'b1;
                    buf_pc_d    = ret_pc_q;
                    buf_instr_d = bus.if_resp_instr_i;
                    buf_err_d   = bus.if_resp_err_i;
                    state_d     = bus.if_resp_err_i ? ST_HALT : ST_REQ;
                end
            end
            ST_DROP: begin
                if (resp_hs) begin
                    state_d = ST_REQ;
                end
            end
            default: ;
        endcase

        // Redirect overrides everything. A response consumed in the same cycle (WAIT or DROP)
        // closes the outstanding request, so fetch can restart without waiting for another.
        if (bus.redirect_valid_i) begin
            pc_d        = {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            buf_valid_d = 1'b0;
            case (state_q)
                ST_WAIT: state_d = resp_hs ? ST_REQ : ST_DROP;
                ST_DROP: state_d = resp_hs ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            ret_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            buf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ret_pc_q    <= ret_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_err_q   <= buf_err_d;
        end
    end

    assign bus.if_req_valid_o  = req_valid;
    assign bus.if_req_pc_o     = pc_q;
    assign bus.if_resp_ready_o = resp_ready;
    assign bus.ifu_o_valid_o   = buf_valid_q;
    assign bus.ifu_o_pc_o      = buf_pc_q;
    assign bus.ifu_o_instr_o   = buf_instr_q;
    assign bus.ifu_o_err_o     = buf_err_q;

endmodule

// File: tb/tb_fetch_ifu_ctrl.sv
// Bench for fetch_ifu_ctrl: directed scenarios plus randomized traffic, all checked every
// cycle against a transaction-level model (pc, outstanding/stale flags, halt flag, buffer).
module tb_fetch_ifu_ctrl;
    localparam int          PW     = 32;
    localparam int          IW     = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ifu_ctrl_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    fetch_ifu_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state
    logic [31:0] m_pc, m_out_pc, m_bpc, m_binstr;
    bit          m_out, m_stale, m_halt, m_bv, m_berr;

    // stimulus knobs
    int          k_req_rdy   = 100;
    int          k_dec_rdy   = 100;
    int          k_lat_min   = 0;
    int          k_lat_max   = 0;
    int          k_err_pct   = 0;
    int          k_redir_pct = 0;
    bit          k_rand_instr = 0;
    logic [31:0] k_err_pc    = 32'h1;
    bit          f_redir     = 0;
    logic [31:0] f_pc        = '0;

    // bus responder
    bit          r_busy;
    int          r_cnt;
    logic [31:0] r_instr;
    bit          r_err;

    // transaction logs
    logic [31:0] req_pc_q[$];
    int          req_cyc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    bit          pop_err_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pct(input int p);
        return (int'($urandom_range(99)) < p);
    endfunction

    task automatic clear_logs();
        req_pc_q.delete(); req_cyc_q.delete();
        pop_pc_q.delete(); pop_instr_q.delete(); pop_err_q.delete();
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_out_pc = '0; m_out = 0; m_stale = 0; m_halt = 0;
        m_bv = 0; m_bpc = '0; m_binstr = '0; m_berr = 0;
        r_busy = 0; r_cnt = 0; r_instr = '0; r_err = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid_i = 1'b0; bus.redirect_pc_i = '0;
        bus.if_req_ready_i = 1'b0; bus.if_resp_valid_i = 1'b0;
        bus.if_resp_err_i = 1'b0; bus.if_resp_instr_i = '0; bus.ifu_o_ready_i = 1'b0;
        #1;
        chk("rst_ifu_valid",  32'(bus.ifu_o_valid_o),   32'd0);
        chk("rst_ifu_pc",     bus.ifu_o_pc_o,           32'd0);
        chk("rst_ifu_instr",  bus.ifu_o_instr_o,        32'd0);
        chk("rst_ifu_err",    32'(bus.ifu_o_err_o),     32'd0);
        chk("rst_req_valid",  32'(bus.if_req_valid_o),  32'd0);
        chk("rst_resp_ready", 32'(bus.if_resp_ready_o), 32'd0);
        chk("rst_req_pc",     bus.if_req_pc_o,          RST_PC);
        model_reset();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, compare DUT outputs with the model, advance model and responder.
    task automatic step();
        bit bf, e_rv, e_rr, qhs, rhs, redir, dec, rrdy, rv;
        logic [31:0] rpc;
        @(negedge clk);
        cyc++;
        rrdy = pct(k_req_rdy);
        dec  = pct(k_dec_rdy);
        if (f_redir) begin
            redir = 1; rpc = f_pc; f_redir = 0;
        end else begin
            redir = pct(k_redir_pct); rpc = $urandom;
        end
        rv = r_busy && (r_cnt == 0);
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = rpc;
        bus.if_req_ready_i   = rrdy;
        bus.ifu_o_ready_i    = dec;
        bus.if_resp_valid_i  = rv;
        bus.if_resp_instr_i  = rv ? r_instr : $urandom;
        bus.if_resp_err_i    = rv ? r_err : 1'($urandom_range(1));
        #1;

        bf   = !m_bv || dec;
        e_rv = !m_out && !m_halt && bf && !redir;
        e_rr = m_out && (m_stale || bf);
        chk("req_valid",  32'(bus.if_req_valid_o),  32'(e_rv));
        chk("req_pc",     bus.if_req_pc_o,          m_pc);
        chk("resp_ready", 32'(bus.if_resp_ready_o), 32'(e_rr));
        chk("ifu_valid",  32'(bus.ifu_o_valid_o),   32'(m_bv));
        if (m_bv) begin
            chk("ifu_pc",    bus.ifu_o_pc_o,        m_bpc);
            chk("ifu_instr", bus.ifu_o_instr_o,     m_binstr);
            chk("ifu_err",   32'(bus.ifu_o_err_o),  32'(m_berr));
        end

        qhs = e_rv && rrdy;
        rhs = e_rr && rv;
        if (qhs) begin
            req_pc_q.push_back(m_pc); req_cyc_q.push_back(cyc);
            $display("cycle %0d REQ pc=%h", cyc, m_pc);
        end
        if (m_bv && dec) begin
            pop_pc_q.push_back(m_bpc); pop_instr_q.push_back(m_binstr); pop_err_q.push_back(m_berr);
            $display("cycle %0d POP pc=%h instr=%h err=%0d", cyc, m_bpc, m_binstr, m_berr);
        end
        if (redir) $display("cycle %0d REDIRECT pc=%h", cyc, rpc);

        if (redir)                 m_bv = 0;
        else if (rhs && !m_stale) begin
            m_bv = 1; m_bpc = m_out_pc; m_binstr = r_instr; m_berr = r_err;
        end else if (dec)          m_bv = 0;

        if (redir)                            m_halt = 0;
        else if (rhs && !m_stale && r_err)    m_halt = 1;

        if (rhs) begin
            m_out = 0; m_stale = 0;
        end else if (redir && m_out) begin
            m_stale = 1;
        end
        if (qhs) begin
            m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        if (redir) m_pc = {rpc[31:2], 2'b00};

        if (rv && bus.if_resp_ready_o) r_busy = 0;
        else if (r_busy && r_cnt > 0)  r_cnt--;
        if (bus.if_req_valid_o && rrdy) begin
            r_busy  = 1;
            r_cnt   = int'($urandom_range(k_lat_max, k_lat_min));
            r_instr = k_rand_instr ? $urandom : (bus.if_req_pc_o ^ 32'h5A5A_0000);
            r_err   = (bus.if_req_pc_o == k_err_pc) || pct(k_err_pct);
        end
        @(posedge clk);
    endtask

    task automatic step_until_reqs(input string name, input int n);
        int guard = 0;
        while (req_pc_q.size() < n && guard < 50) begin
            step();
            guard++;
        end
        chk(name, 32'(req_pc_q.size()), 32'(n));
    endtask

    initial begin
        model_reset();

        // back-to-back fetch from reset
        do_reset(2); clear_logs();
        repeat (8) step();
        chk("s1_req0", req_pc_q[0], 32'h8000_0000);
        chk("s1_req1", req_pc_q[1], 32'h8000_0004);
        chk("s1_req2", req_pc_q[2], 32'h8000_0008);
        chk("s1_gap",  32'(req_cyc_q[1] - req_cyc_q[0]), 32'd2);
        chk("s1_pop0_pc",    pop_pc_q[0],    32'h8000_0000);
        chk("s1_pop0_instr", pop_instr_q[0], 32'hDA5A_0000);
        chk("s1_pop1_pc",    pop_pc_q[1],    32'h8000_0004);

        // decode stall: buffer holds, no further requests, then resumes in order
        do_reset(1); clear_logs();
        k_dec_rdy = 0;
        repeat (10) step();
        #1;
        chk("s2_nreq",       32'(req_pc_q.size()),     32'd1);
        chk("s2_hold_valid", 32'(bus.ifu_o_valid_o),   32'd1);
        chk("s2_hold_pc",    bus.ifu_o_pc_o,           32'h8000_0000);
        k_dec_rdy = 100;
        repeat (8) step();
        chk("s2_pop0", pop_pc_q[0], 32'h8000_0000);
        chk("s2_pop1", pop_pc_q[1], 32'h8000_0004);
        chk("s2_pop2", pop_pc_q[2], 32'h8000_0008);

        // redirect while waiting; late response must be dropped
        do_reset(1); clear_logs();
        k_lat_min = 3; k_lat_max = 3;
        step_until_reqs("s3_wait", 1);
        f_redir = 1; f_pc = 32'h0000_1003;
        repeat (14) step();
        chk("s3_req_after", req_pc_q[1], 32'h0000_1000);
        chk("s3_first_pop", pop_pc_q[0], 32'h0000_1000);

        // redirect together with a response handshake
        do_reset(1); clear_logs();
        k_lat_min = 0; k_lat_max = 0;
        step_until_reqs("s4_wait", 2);
        f_redir = 1; f_pc = 32'h0000_2000;
        step();
        #1;
        chk("s4_valid_cleared", 32'(bus.ifu_o_valid_o), 32'd0);
        repeat (4) step();
        chk("s4_req_target", req_pc_q[2], 32'h0000_2000);

        // bus error halts fetch until redirect
        do_reset(1); clear_logs();
        k_err_pc = 32'h8000_0004;
        repeat (10) step();
        chk("s5_nreq",     32'(req_pc_q.size()), 32'd2);
        chk("s5_err_pc",   pop_pc_q[1],          32'h8000_0004);
        chk("s5_err_flag", 32'(pop_err_q[1]),    32'd1);
        chk("s5_ok_flag",  32'(pop_err_q[0]),    32'd0);
        k_err_pc = 32'h1;
        f_redir = 1; f_pc = 32'h0000_0100;
        repeat (4) step();
        chk("s5_restart", req_pc_q[2], 32'h0000_0100);

        // pc wrap, then reset in the middle of WAIT
        do_reset(1); clear_logs();
        f_redir = 1; f_pc = 32'hFFFF_FFFC;
        repeat (6) step();
        chk("s6_req_top",  req_pc_q[0], 32'hFFFF_FFFC);
        chk("s6_req_wrap", req_pc_q[1], 32'h0000_0000);
        k_lat_min = 3; k_lat_max = 3;
        step_until_reqs("s6_wait", 3);
        do_reset(1); clear_logs();
        repeat (3) step();
        chk("s6_req_after_rst", req_pc_q[0], RST_PC);

        // randomized traffic
        k_rand_instr = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                k_req_rdy   = int'($urandom_range(100, 30));
                k_dec_rdy   = int'($urandom_range(100, 20));
                k_lat_min   = 0;
                k_lat_max   = int'($urandom_range(4));
                k_err_pct   = int'($urandom_range(8));
                k_redir_pct = int'($urandom_range(10));
            end
            if ($urandom_range(999) == 0) begin
                do_reset(1);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
